// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer between fetch and decode.
// Fetch never loses an instruction when decode stalls. The block also supports
// flush (bubble insert), a sticky halt/resume state, a sideband field carried
// with each instruction, and a saturating counter of decode-stall cycles.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   EMPTY | no entry held, out_valid=0, fetch may present an instruction
//   FULL  | main entry holds the head instruction, skid entry unused
//   SKID  | main and skid both hold entries, fetch is back-pressured
//
// The halted flag is kept separate from the occupancy state. This lets a
// halt freeze the occupancy and the entries, and a resume restore them as
// they were.
module ifid_skid_reg #(
    parameter int                  PC_W      = 16,
    parameter int                  INSTR_W   = 16,
    parameter int                  SIDE_W    = 1,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = {INSTR_W{1'b0}},
    parameter int                  CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [SIDE_W-1:0]  in_side,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [SIDE_W-1:0]  out_side,
    input  logic               flush,
    input  logic               halt_req,
    input  logic               resume,
    output logic               halted,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               halted_q, halted_d;
    logic               in_ready_q, in_ready_d;
    logic [PC_W-1:0]    main_pc_q, skid_pc_q;
    logic [INSTR_W-1:0] main_instr_q, skid_instr_q;
    logic [SIDE_W-1:0]  main_side_q, skid_side_q;
    logic [CNT_W-1:0]   stall_q;

    logic in_xfer, out_xfer, out_valid_w;
    logic load_main_in, load_main_skid, load_skid;

    // The decode side sees only registered state, so there is no in_* to out_* path.
    assign out_valid_w = (state_q != ST_EMPTY) && !halted_q;
    assign in_xfer     = in_valid && in_ready_q;
    assign out_xfer    = out_valid_w && out_ready;

    // Next occupancy state and the entry-load selects. Flush overrides every transfer.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ST_FULL;
                        load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d        = ST_FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // halt_req wins over resume. A resume while running falls through as a no-op.
    // in_ready is registered and looks ahead to the next state and halt flag.
    always_comb begin
        halted_d   = halt_req || (halted_q && !resume);
        in_ready_d = (state_d != ST_SKID) && !halted_d;
    end

    // Control state: occupancy, halt flag, registered in_ready and the stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            halted_q   <= 1'b0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            in_ready_q <= in_ready_d;
            if (out_valid_w && !out_ready && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Entry storage. Flush wipes both entries so stale data cannot resurface.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            main_side_q  <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_side_q  <= '0;
        end else if (flush) begin
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            main_side_q  <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_side_q  <= '0;
        end else begin
            if (load_main_in) begin
                main_pc_q    <= in_pc;
                main_instr_q <= in_instr;
                main_side_q  <= in_side;
            end else if (load_main_skid) begin
                main_pc_q    <= skid_pc_q;
                main_instr_q <= skid_instr_q;
                main_side_q  <= skid_side_q;
            end
            if (load_skid) begin
                skid_pc_q    <= in_pc;
                skid_instr_q <= in_instr;
                skid_side_q  <= in_side;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_w;
    assign out_pc    = main_pc_q;
    assign out_instr = out_valid_w ? main_instr_q : NOP_INSTR;
    assign out_side  = out_valid_w ? main_side_q : {SIDE_W{1'b0}};
    assign halted    = halted_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed bench for ifid_skid_reg. A scoreboard queue records every accepted
// instruction and checks it against what decode takes, in order.
module tb_ifid_skid_reg;

    localparam int          PC_W    = 16;
    localparam int          INSTR_W = 16;
    localparam int          SIDE_W  = 1;
    localparam int          CNT_W   = 3;
    localparam logic [15:0] NOP     = 16'h0013;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic [SIDE_W-1:0]  in_side;
    logic               out_valid, out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [SIDE_W-1:0]  out_side;
    logic               flush, halt_req, resume, halted;
    logic [1:0]         occupancy;
    logic [CNT_W-1:0]   stall_cnt;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [SIDE_W-1:0]  side;
    } ent_t;

    ent_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    ifid_skid_reg #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .SIDE_W(SIDE_W),
        .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_side(in_side),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_side(out_side),
        .flush(flush), .halt_req(halt_req), .resume(resume), .halted(halted),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                         input logic s, input logic ordy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        in_side   = s;
        out_ready = ordy;
    endtask

    // Observe the handshake mid-cycle, update the scoreboard, then advance one edge.
    task automatic step();
        ent_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed pc=%0h expected=no output", out_pc);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
                chk("sb_side", out_side, e.side);
            end
        end
        if (flush) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            e.pc    = in_pc;
            e.instr = in_instr;
            e.side  = in_side;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0; halt_req = 1'b0; resume = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, NOP);
        chk("rst_out_side", out_side, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_halted", halted, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Streaming at full throughput.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(2 * i), 16'(16'h1111 * (i + 1)), 1'(i % 2), 1'b1);
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, 2 * i);
            chk("stream_instr", out_instr, 32'(16'h1111 * (i + 1)));
            chk("stream_side", out_side, i % 2);
            chk("stream_occ", occupancy, 1);
            chk("stream_in_ready", in_ready, 1);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_instr", out_instr, NOP);
        chk("drain_occ", occupancy, 0);
        chk("stream_stall", stall_cnt, 0);

        // Backpressure into the skid entry.
        drive(1'b1, 16'h0010, 16'h5555, 1'b0, 1'b1);
        step();
        chk("bp_full_pc", out_pc, 16'h0010);
        drive(1'b1, 16'h0012, 16'h6666, 1'b1, 1'b0);
        step();
        chk("bp_occ2", occupancy, 2);
        chk("bp_in_ready0", in_ready, 0);
        chk("bp_stall1", stall_cnt, 1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        chk("bp_hold_pc", out_pc, 16'h0010);
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_stall3", stall_cnt, 3);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        chk("bp_second_pc", out_pc, 16'h0012);
        chk("bp_second_instr", out_instr, 16'h6666);
        chk("bp_occ1", occupancy, 1);
        chk("bp_in_ready1", in_ready, 1);
        step();
        chk("bp_occ0", occupancy, 0);
        chk("bp_stall_hold", stall_cnt, 3);

        // Flush while two entries are held.
        drive(1'b1, 16'h0014, 16'h5A5A, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0016, 16'h6B6B, 1'b1, 1'b0);
        step();
        chk("fl_occ2", occupancy, 2);
        flush = 1'b1;
        drive(1'b1, 16'h0020, 16'h9999, 1'b1, 1'b0);
        step();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_instr", out_instr, NOP);
        chk("fl_side", out_side, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_stall", stall_cnt, 5);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        chk("fl_no_0020", out_valid, 0);

        // Flush discards an instruction accepted in the same cycle.
        flush = 1'b1;
        drive(1'b1, 16'h0024, 16'hAAAA, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        chk("fl_xfer_valid", out_valid, 0);
        chk("fl_xfer_occ", occupancy, 0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        chk("fl_no_0024", out_valid, 0);

        // Halt with a held entry, then resume.
        drive(1'b1, 16'h0030, 16'h7777, 1'b1, 1'b0);
        step();
        halt_req = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        halt_req = 1'b0;
        chk("halt_flag", halted, 1);
        chk("halt_valid", out_valid, 0);
        chk("halt_instr", out_instr, NOP);
        chk("halt_in_ready", in_ready, 0);
        chk("halt_stall", stall_cnt, 6);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0032, 16'h8888, 1'b0, 1'b1);
            step();
            chk("halt_frozen_flag", halted, 1);
            chk("halt_frozen_valid", out_valid, 0);
            chk("halt_frozen_occ", occupancy, 1);
            chk("halt_frozen_in_ready", in_ready, 0);
        end
        chk("halt_frozen_stall", stall_cnt, 6);
        resume = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        resume = 1'b0;
        chk("resume_flag", halted, 0);
        chk("resume_valid", out_valid, 1);
        chk("resume_pc", out_pc, 16'h0030);
        chk("resume_instr", out_instr, 16'h7777);
        chk("resume_side", out_side, 1);
        chk("resume_in_ready", in_ready, 1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        chk("resume_drain_occ", occupancy, 0);

        // halt_req beats resume, and flush while halted keeps the block halted.
        halt_req = 1'b1;
        resume   = 1'b1;
        step();
        halt_req = 1'b0;
        resume   = 1'b0;
        chk("halt_wins", halted, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_halted_flag", halted, 1);
        chk("flush_halted_occ", occupancy, 0);
        chk("flush_halted_in_ready", in_ready, 0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume2_flag", halted, 0);
        chk("resume2_in_ready", in_ready, 1);
        chk("resume2_valid", out_valid, 0);

        // Stall counter saturation.
        drive(1'b1, 16'h0040, 16'hCCCC, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("sat_stall", stall_cnt, 7);
        chk("sat_pc", out_pc, 16'h0040);
        chk("sat_valid", out_valid, 1);

        // Asynchronous reset in the middle of a stall.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_instr", out_instr, NOP);
        chk("arst_side", out_side, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_halted", halted, 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 16'h0050, 16'hDDDD, 1'b1, 1'b1);
        step();
        chk("post_rst_pc", out_pc, 16'h0050);
        chk("post_rst_occ", occupancy, 1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        chk("post_rst_drain", occupancy, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
